bram_fifo_ctrl: RTL and testbench



---
 rtl/bram_fifo_ctrl_if.sv | 39 +++
 rtl/bram_fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_fifo_ctrl_if.sv
// Bus bundle for bram_fifo_ctrl: push side, FWFT read stream, status and
// the block-RAM port A/B signals. Signal names keep the original port names.
interface bram_fifo_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              FLUSH;
  logic              WR_EN;
  logic [17:0]       WR_DATA;
  logic              FULL;
  logic              ALMOST_FULL;
  logic              OVF;
  logic              RD_VALID;
  logic              RD_READY;
  logic [17:0]       RD_DATA;
  logic [ADDR_W:0]   LEVEL;
  logic [ADDR_W-1:0] RAM_ADDRA;
  logic [15:0]       RAM_DIA;
  logic [1:0]        RAM_DIPA;
  logic              RAM_ENA;
  logic              RAM_WEA;
  logic [ADDR_W-1:0] RAM_ADDRB;
  logic              RAM_ENB;
  logic [15:0]       RAM_DOB;
  logic [1:0]        RAM_DOPB;

  // controller side
  modport slave (
    input  FLUSH, WR_EN, WR_DATA, RD_READY, RAM_DOB, RAM_DOPB,
    output FULL, ALMOST_FULL, OVF, RD_VALID, RD_DATA, LEVEL,
           RAM_ADDRA, RAM_DIA, RAM_DIPA, RAM_ENA, RAM_WEA, RAM_ADDRB, RAM_ENB
  );

  // producer / consumer / RAM side
  modport master (
    output FLUSH, WR_EN, WR_DATA, RD_READY, RAM_DOB, RAM_DOPB,
    input  FULL, ALMOST_FULL, OVF, RD_VALID, RD_DATA, LEVEL,
           RAM_ADDRA, RAM_DIA, RAM_DIPA, RAM_ENA, RAM_WEA, RAM_ADDRB, RAM_ENB
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller around a 2^ADDR_W x 18 dual-port block RAM.
// Port A is written on push; port B is read ahead into a 2-entry output
// buffer that presents a first-word-fall-through valid/ready stream.
module bram_fifo_ctrl #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned AFULL_THRESH = 1008
) (
  input  logic            CLK,
  input  logic            RST_N,
  bram_fifo_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W + 1)'(AFULL_THRESH);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   mem_count, mem_count_nx;
  logic              inflight;
  logic [1:0]        ob_count, ob_count_nx;
  logic [17:0]       ob0, ob1;
  logic              full_q, afull_q, ovf_q;
  logic [ADDR_W:0]   level_q, level_nx;
  logic              push, pop, issue;
  logic [17:0]       cap_word;

  // Handshake decode and next-state counts; RST_N gating keeps the RAM
  // enables low for the whole reset, FLUSH drops any same-cycle push/issue.
  always_comb begin
    push         = bus.WR_EN & ~full_q & ~bus.FLUSH & RST_N;
    pop          = (ob_count != 2'd0) & bus.RD_READY;
    issue        = (mem_count != '0) & (((ob_count + 2'(inflight)) < 2'd2) | pop)
                   & ~bus.FLUSH & RST_N;
    mem_count_nx = mem_count + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(issue);
    ob_count_nx  = ob_count + 2'(inflight) - 2'(pop);
    level_nx     = mem_count_nx + (ADDR_W + 1)'(issue) + (ADDR_W + 1)'(ob_count_nx);
    cap_word     = {bus.RAM_DOPB, bus.RAM_DOB};
  end

  // RAM pointers, stored-word count and read-in-flight flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
    end else if (bus.FLUSH) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      mem_count <= mem_count_nx;
      inflight  <= issue;
    end
  end

  // Two-entry output buffer; a capture landing with a pop goes behind the
  // surviving entry so stream order is kept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ob0      <= '0;
      ob1      <= '0;
      ob_count <= 2'd0;
    end else if (bus.FLUSH) begin
      ob0      <= '0;
      ob1      <= '0;
      ob_count <= 2'd0;
    end else begin
      unique case ({inflight, pop})
        2'b01: ob0 <= ob1;
        2'b10: begin
          if (ob_count == 2'd0) ob0 <= cap_word;
          else                  ob1 <= cap_word;
        end
        2'b11: begin
          if (ob_count == 2'd1) begin
            ob0 <= cap_word;
          end else begin
            ob0 <= ob1;
            ob1 <= cap_word;
          end
        end
        default: ;
      endcase
      ob_count <= ob_count_nx;
    end
  end

  // Registered status reflecting the state after this edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      level_q <= '0;
    end else if (bus.FLUSH) begin
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      level_q <= '0;
    end else begin
      full_q  <= (mem_count_nx == FULL_CNT);
      afull_q <= (mem_count_nx >= AFULL_CNT);
      ovf_q   <= bus.WR_EN & full_q;
      level_q <= level_nx;
    end
  end

  assign bus.FULL        = full_q;
  assign bus.ALMOST_FULL = afull_q;
  assign bus.OVF         = ovf_q;
  assign bus.RD_VALID    = (ob_count != 2'd0);
  assign bus.RD_DATA     = ob0;
  assign bus.LEVEL       = level_q;
  assign bus.RAM_ADDRA   = wptr;
  assign bus.RAM_DIA     = bus.WR_DATA[15:0];
  assign bus.RAM_DIPA    = bus.WR_DATA[17:16];
  assign bus.RAM_ENA     = push;
  assign bus.RAM_WEA     = push;
  assign bus.RAM_ADDRB   = rptr;
  assign bus.RAM_ENB     = issue;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl: behavioural RAM, a scoreboard
// queue filled by the stimulus and a monitor that pops on every handshake.
module tb_bram_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_fifo_ctrl_if #(.ADDR_W(10)) bus ();

  bram_fifo_ctrl #(.ADDR_W(10), .AFULL_THRESH(1008)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  // behavioural block RAM: synchronous write on A, registered read on B
  logic [17:0] ram [1024];
  logic [17:0] dob_r = '0;
  always @(posedge clk) begin
    if (bus.RAM_ENA && bus.RAM_WEA) ram[bus.RAM_ADDRA] <= {bus.RAM_DIPA, bus.RAM_DIA};
    if (bus.RAM_ENB) dob_r <= ram[bus.RAM_ADDRB];
  end
  assign bus.RAM_DOB  = dob_r[15:0];
  assign bus.RAM_DOPB = dob_r[17:16];

  int compared = 0;
  int mismatched = 0;
  logic [17:0] exp_q [$];

  function automatic void check(string name, longint act, longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // monitor: a handshake completes at the next posedge; compare the head now
  logic [17:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && bus.RD_VALID && bus.RD_READY) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rd_unexpected: got 0x%0h, required no output", bus.RD_DATA);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", bus.RD_DATA, mon_exp);
      end
    end
    if (bus.RAM_ENA && bus.RAM_ENB)
      check("ram_collision", bus.RAM_ADDRA == bus.RAM_ADDRB, 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // one clock: outputs settle 1 time unit after the edge, then LEVEL is
  // compared against the number of words the model holds
  task automatic step();
    @(posedge clk);
    #1;
    check("level", bus.LEVEL, exp_q.size());
  endtask

  task automatic drive(bit we, logic [17:0] d, bit rdy, bit accept);
    bus.WR_EN    = we;
    bus.WR_DATA  = d;
    bus.RD_READY = rdy;
    if (we && accept) exp_q.push_back(d);
  endtask

  task automatic drain(int budget);
    int n = 0;
    drive(1'b0, '0, 1'b1, 1'b0);
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic latency_probe(logic [17:0] d);
    step();
    drive(1'b1, d, 1'b1, 1'b1);
    #1;
    check("wea_c0", bus.RAM_WEA, 1);
    check("ena_c0", bus.RAM_ENA, 1);
    check("dia_c0", {bus.RAM_DIPA, bus.RAM_DIA}, d);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("enb_c1", bus.RAM_ENB, 1);
    step();
    check("valid_c2", bus.RD_VALID, 0);
    step();
    check("valid_c3", bus.RD_VALID, 1);
    check("data_c3", bus.RD_DATA, d);
    step();
    check("valid_after_pop", bus.RD_VALID, 0);
  endtask

  initial begin
    logic [17:0] d;
    int pushed;
    int cyc;

    bus.FLUSH = 1'b0;
    drive(1'b1, 18'h15555, 1'b0, 1'b0);

    // reset state, with WR_EN held high to show the RAM stays disabled
    repeat (3) @(posedge clk);
    #1;
    check("rst_full", bus.FULL, 0);
    check("rst_afull", bus.ALMOST_FULL, 0);
    check("rst_ovf", bus.OVF, 0);
    check("rst_valid", bus.RD_VALID, 0);
    check("rst_data", bus.RD_DATA, 0);
    check("rst_level", bus.LEVEL, 0);
    check("rst_ena", bus.RAM_ENA, 0);
    check("rst_wea", bus.RAM_WEA, 0);
    check("rst_enb", bus.RAM_ENB, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);

    // single word: address 0 on both ports, 3-cycle latency
    step();
    drive(1'b1, 18'h3ABCD, 1'b1, 1'b1);
    #1;
    check("addra_first", bus.RAM_ADDRA, 0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("enb_first", bus.RAM_ENB, 1);
    check("addrb_first", bus.RAM_ADDRB, 0);
    step();
    check("valid_cycle2", bus.RD_VALID, 0);
    step();
    check("valid_cycle3", bus.RD_VALID, 1);
    check("data_cycle3", bus.RD_DATA, 18'h3ABCD);
    step();
    check("valid_drained", bus.RD_VALID, 0);

    // fill with the consumer stalled, one push every 4 cycles so the
    // read-ahead settles: buffer holds min(n,2), RAM holds the rest
    for (int n = 1; n <= 1026; n++) begin
      step();
      drive(1'b1, 18'($urandom), 1'b0, 1'b1);
      step();
      drive(1'b0, '0, 1'b0, 1'b0);
      step();
      step();
      check("fill_full", bus.FULL, (n == 1026));
      check("fill_afull", bus.ALMOST_FULL, (n - 2 >= 1008));
    end

    // push while full is dropped and pulses OVF for one cycle
    step();
    drive(1'b1, 18'h2AAAA, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("ovf_pulse", bus.OVF, 1);
    check("ovf_full", bus.FULL, 1);
    check("ovf_level", bus.LEVEL, 1026);
    step();
    check("ovf_clear", bus.OVF, 0);

    // drain with a push every cycle: gap-free output, pointers wrap
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 1200; k++) begin
      step();
      check("gapfree_valid", bus.RD_VALID, 1);
      check("gapfree_notfull", bus.FULL, 0);
      drive(1'b1, 18'($urandom), 1'b1, 1'b1);
    end
    step();
    drain(1200);

    // random push / ready traffic
    pushed = 0;
    cyc = 0;
    while (pushed < 5000 && cyc < 40000) begin
      step();
      cyc++;
      d = 18'($urandom);
      if (($urandom % 2 == 0) && exp_q.size() < 900) begin
        drive(1'b1, d, 1'($urandom % 2), 1'b1);
        pushed++;
      end else begin
        drive(1'b0, d, 1'($urandom % 2), 1'b0);
      end
    end
    check("random_pushed", pushed, 5000);
    step();
    drain(2000);

    // flush with queued words and a read in flight
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      drive(1'b1, 18'($urandom), 1'b0, 1'b1);
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) step();
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b1, 18'h3FFFF, 1'b0, 1'b0);
    bus.FLUSH = 1'b1;
    exp_q.delete();
    #1;
    check("flush_no_write", bus.RAM_WEA, 0);
    step();
    bus.FLUSH = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    check("flush_valid", bus.RD_VALID, 0);
    check("flush_full", bus.FULL, 0);
    check("flush_ovf", bus.OVF, 0);
    step();
    check("flush_still_empty", bus.RD_VALID, 0);
    drive(1'b1, 18'h00055, 1'b1, 1'b1);
    step();
    drain(20);

    // asynchronous reset in the middle of a burst
    for (int k = 0; k < 40; k++) begin
      step();
      drive(1'b1, 18'($urandom), 1'($urandom % 2), 1'b1);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", bus.RD_VALID, 0);
    check("arst_data", bus.RD_DATA, 0);
    check("arst_level", bus.LEVEL, 0);
    check("arst_full", bus.FULL, 0);
    check("arst_afull", bus.ALMOST_FULL, 0);
    check("arst_ovf", bus.OVF, 0);
    check("arst_ena", bus.RAM_ENA, 0);
    check("arst_enb", bus.RAM_ENB, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    latency_probe(18'h12345);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
